serial_adder: RTL

- Bit-serial ripple adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Uses a single full-adder bit-cell (x, y, c_in -> s, c_out) with a registered carry that is fed back each cycle.
- Sits directly downstream of the one-bit full-adder cell. It sequences operand bits into that cell and collects its sum and carry outputs.
- Trades latency for area in the team's arithmetic datapath.

---
 rtl/serial_adder.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock,
// LSB first, through a single full-adder cell with a registered carry feedback.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;

  logic fa_s;
  logic fa_c;

  // Full-adder bit-cell fed from the operand LSBs and the carry flop.
  always_comb begin
    fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state: operand capture, per-bit shifting and result commit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = x;
          b_d     = y;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Sum bit enters at the MSB so after WIDTH steps bit 0 lands at index 0.
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = fa_s;
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        carry_d           = fa_c;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          s_d     = psum_d;
          c_out_d = fa_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts a running addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

  // Outputs decode directly from registered state and result.
  always_comb begin
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    s     = s_q;
    c_out = c_out_q;
  end

endmodule
